issue_scoreboard: RTL and testbench
===================================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32 (2**REG_ADDR_WIDTH), meaning architectural register count.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 8, meaning maximum tracked in-flight long-latency writes.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port issue_valid  input  1  decoded instruction presented for issue.
REQ-006 SHALL have ports issue_rs1, issue_rs2, issue_rs3  input  REG_ADDR_WIDTH each  source register addresses.
REQ-007 SHALL have port issue_uses_rs3  input  1  rs3 is a live source (FMADD/FMSUB).
REQ-008 SHALL have port issue_rd  input  REG_ADDR_WIDTH  destination register.
REQ-009 SHALL have port issue_reg_write  input  1  instruction writes rd.
REQ-010 SHALL have port issue_long  input  1  instruction goes to a multi-cycle unit (FPU, DIV/REM, load).
REQ-011 SHALL have ports wb_valid  input  1, and wb_rd  input  REG_ADDR_WIDTH  long-latency writeback completion.
REQ-012 SHALL have port issue_stall  output  1  decode must hold; instruction not accepted.
REQ-013 SHALL have ports stall_raw, stall_waw, stall_full  output  1 each  stall cause flags.
REQ-014 SHALL have port pending_mask  output  NUM_REGS  per-register pending-write bits.
REQ-015 SHALL have port outstanding_cnt  output  $clog2(MAX_OUTSTANDING+1)  tracked in-flight writes.
REQ-016 SHALL have ports idle  output  1  (outstanding_cnt==0), and err_spurious_wb  output  1  sticky error.

Function
REQ-017 SHALL treat an issue as accepted when issue_valid && !issue_stall.
REQ-018 SHALL compute stall flags combinationally from registered pending_mask/outstanding_cnt only; same-cycle writebacks are not bypassed into stall.
REQ-019 SHALL assert stall_raw when issue_valid and pending_mask[rs1] or pending_mask[rs2] or (issue_uses_rs3 && pending_mask[rs3]).
REQ-020 SHALL assert stall_waw when issue_valid && issue_reg_write && issue_rd!=0 && pending_mask[issue_rd].
REQ-021 SHALL assert stall_full when issue_valid && issue_long && issue_reg_write && issue_rd!=0 && outstanding_cnt==MAX_OUTSTANDING.
REQ-022 SHALL drive issue_stall = stall_raw | stall_waw | stall_full; all flags 0 when issue_valid=0.
REQ-023 SHALL never set pending_mask[0]; register 0 sources never cause stall.
REQ-024 SHALL on an accepted issue with issue_long && issue_reg_write && issue_rd!=0 set pending_mask[issue_rd] and increment outstanding_cnt next cycle.
REQ-025 SHALL not track short ops or long ops with rd==0 or reg_write==0 (no mask/count change).
REQ-026 SHALL on wb_valid with pending_mask[wb_rd]==1 clear that bit and decrement outstanding_cnt next cycle.
REQ-027 SHALL on wb_valid with pending_mask[wb_rd]==0 (incl. wb_rd==0) change no mask/count state and set err_spurious_wb, which stays 1 until reset.
REQ-028 SHALL on a same-cycle tracked issue and valid writeback (necessarily different registers per REQ-020) apply both: set one bit, clear the other, outstanding_cnt unchanged.
REQ-029 SHALL keep outstanding_cnt equal to popcount(pending_mask) at all times; never exceed MAX_OUTSTANDING nor wrap below 0.
REQ-030 SHALL be a pure tracker: decode flush does not clear pending state (in-flight writes still complete).

Reset
REQ-031 SHALL on rst=1 at a clock edge clear pending_mask, outstanding_cnt and err_spurious_wb to 0, overriding any same-cycle issue or writeback.
REQ-032 SHALL hold idle=1 and all stall flags 0 (for issue_valid=0) in the cycle after reset.
REQ-033 SHALL, if rst is asserted mid-operation, discard all tracked writes; later writebacks for them raise err_spurious_wb.

Verification
REQ-034 Bench SHALL cover: FDIV rd=5 long accepted -> pending_mask[5]=1, cnt=1; next FADD rs1=5 -> issue_stall=1, stall_raw=1 until wb_rd=5, then accepted the cycle after wb.
REQ-035 Bench SHALL cover: load rd=7 pending, then long write rd=7 -> stall_waw=1, stall_raw=0; ADD rd=7 (short) also stalls on WAW.
REQ-036 Bench SHALL cover: 8 long issues rd=1..8 -> cnt=8; 9th long rd=9 -> stall_full=1; short ADD rd=9 not stalled; wb_rd=1 -> next cycle rd=9 long accepted, cnt=8.
REQ-037 Bench SHALL cover: same cycle accept long rd=3 and wb_rd=2 (pending) -> mask bit3=1, bit2=0, cnt unchanged.
REQ-038 Bench SHALL cover: FMADD rs3=4 with pending[4]=1 and issue_uses_rs3=0 -> no stall; with issue_uses_rs3=1 -> stall_raw=1; rd=0 long issue -> mask unchanged.
REQ-039 Bench SHALL cover: wb_rd=6 with pending[6]=0 -> err_spurious_wb=1 sticky, cnt unchanged; rst with cnt=3 -> cnt=0, mask=0, err=0, idle=1.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Purpose: per-register pending-write scoreboard that holds issue on RAW/WAW hazards and when the in-flight tracker is full.
// Latency: stall flags are combinational from registered state; mask/count/error update on the next rising edge.
// Backpressure: issue_stall holds decode; writebacks are always accepted and are never bypassed into the same-cycle stall.
module issue_scoreboard #(
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 8,
    localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS),
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rs3,
    input  logic                      issue_uses_rs3,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic                      issue_reg_write,
    input  logic                      issue_long,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic                      issue_stall,
    output logic                      stall_raw,
    output logic                      stall_waw,
    output logic                      stall_full,
    output logic [NUM_REGS-1:0]       pending_mask,
    output logic [CNT_W-1:0]          outstanding_cnt,
    output logic                      idle,
    output logic                      err_spurious_wb
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                err_q;
    logic                err_d;
    logic                rd_nonzero;
    logic                accept;
    logic                track;
    logic                wb_hit;
    logic                wb_spur;

    // Hazard detection from registered state only; a write to x0 never needs tracking.
    always_comb begin
        rd_nonzero  = (issue_rd != '0);
        stall_raw   = issue_valid &&
                      (pending_q[issue_rs1] || pending_q[issue_rs2] ||
                       (issue_uses_rs3 && pending_q[issue_rs3]));
        stall_waw   = issue_valid && issue_reg_write && rd_nonzero && pending_q[issue_rd];
        stall_full  = issue_valid && issue_long && issue_reg_write && rd_nonzero &&
                      (cnt_q == CNT_W'(MAX_OUTSTANDING));
        issue_stall = stall_raw | stall_waw | stall_full;
    end

    // Next-state: a tracked issue and a matching writeback always hit different registers
    // (WAW would otherwise have stalled the issue), so set and clear can both apply.
    always_comb begin
        accept    = issue_valid && !issue_stall;
        track     = accept && issue_long && issue_reg_write && rd_nonzero;
        wb_hit    = wb_valid && pending_q[wb_rd];
        wb_spur   = wb_valid && !pending_q[wb_rd];
        pending_d = pending_q;
        cnt_d     = cnt_q;
        err_d     = err_q | wb_spur;
        if (wb_hit) begin
            pending_d[wb_rd] = 1'b0;
        end
        if (track) begin
            pending_d[issue_rd] = 1'b1;
        end
        if (track && !wb_hit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (wb_hit && !track) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State registers; reset discards every tracked write and the sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // Registered state is exported directly.
    always_comb begin
        pending_mask    = pending_q;
        outstanding_cnt = cnt_q;
        idle            = (cnt_q == '0);
        err_spurious_wb = err_q;
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Purpose: directed table-driven bench for issue_scoreboard plus a tracker-full sequence.
// Latency: stall flags checked mid-cycle before the edge; tracked state checked 1 time unit after it.
// Backpressure: expected stall values are hand-computed per vector.
module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rs1 = '0;
    logic [4:0]  issue_rs2 = '0;
    logic [4:0]  issue_rs3 = '0;
    logic        issue_uses_rs3 = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_reg_write = 1'b0;
    logic        issue_long = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        issue_stall;
    logic        stall_raw;
    logic        stall_waw;
    logic        stall_full;
    logic [31:0] pending_mask;
    logic [3:0]  outstanding_cnt;
    logic        idle;
    logic        err_spurious_wb;

    int total = 0;
    int bad   = 0;

    issue_scoreboard #(.NUM_REGS(32), .MAX_OUTSTANDING(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_rs1       (issue_rs1),
        .issue_rs2       (issue_rs2),
        .issue_rs3       (issue_rs3),
        .issue_uses_rs3  (issue_uses_rs3),
        .issue_rd        (issue_rd),
        .issue_reg_write (issue_reg_write),
        .issue_long      (issue_long),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .issue_stall     (issue_stall),
        .stall_raw       (stall_raw),
        .stall_waw       (stall_waw),
        .stall_full      (stall_full),
        .pending_mask    (pending_mask),
        .outstanding_cnt (outstanding_cnt),
        .idle            (idle),
        .err_spurious_wb (err_spurious_wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic        u3;
        logic [4:0]  rd;
        logic        rw;
        logic        lng;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        rst;
        logic        e_raw;
        logic        e_waw;
        logic        e_full;
        logic [31:0] e_mask;
        logic [3:0]  e_cnt;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(int valid, int rs1, int rs2, int rs3, int u3, int rd, int rw,
                                int lng, int wbv, int wbrd, int r, int e_raw, int e_waw,
                                int e_full, int e_mask, int e_cnt, int e_err);
        vec_t v;
        v.valid  = 1'(valid);
        v.rs1    = 5'(rs1);
        v.rs2    = 5'(rs2);
        v.rs3    = 5'(rs3);
        v.u3     = 1'(u3);
        v.rd     = 5'(rd);
        v.rw     = 1'(rw);
        v.lng    = 1'(lng);
        v.wbv    = 1'(wbv);
        v.wbrd   = 5'(wbrd);
        v.rst    = 1'(r);
        v.e_raw  = 1'(e_raw);
        v.e_waw  = 1'(e_waw);
        v.e_full = 1'(e_full);
        v.e_mask = 32'(e_mask);
        v.e_cnt  = 4'(e_cnt);
        v.e_err  = 1'(e_err);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drive one vector just after an edge, check stall flags mid-cycle, then state after the edge.
    task automatic apply(input vec_t v, input string tag);
        issue_valid     = v.valid;
        issue_rs1       = v.rs1;
        issue_rs2       = v.rs2;
        issue_rs3       = v.rs3;
        issue_uses_rs3  = v.u3;
        issue_rd        = v.rd;
        issue_reg_write = v.rw;
        issue_long      = v.lng;
        wb_valid        = v.wbv;
        wb_rd           = v.wbrd;
        rst             = v.rst;
        #4;
        chk({tag, ".raw"},   32'(stall_raw),   32'(v.e_raw));
        chk({tag, ".waw"},   32'(stall_waw),   32'(v.e_waw));
        chk({tag, ".full"},  32'(stall_full),  32'(v.e_full));
        chk({tag, ".stall"}, 32'(issue_stall), 32'(v.e_raw | v.e_waw | v.e_full));
        @(posedge clk);
        #1;
        chk({tag, ".mask"},  pending_mask,          v.e_mask);
        chk({tag, ".cnt"},   32'(outstanding_cnt),  32'(v.e_cnt));
        chk({tag, ".err"},   32'(err_spurious_wb),  32'(v.e_err));
        chk({tag, ".idle"},  32'(idle),             32'(v.e_cnt == 4'd0));
    endtask

    vec_t tbl[27];

    initial begin
        //           vld rs1 rs2 rs3 u3 rd rw lng wbv wbrd rst  raw waw full  mask       cnt err
        tbl[0]  = mk(0,  0,  0,  0,  0, 0, 0, 0,  0,  0,   1,   0,  0,  0,    'h0,       0,  0); // reset
        tbl[1]  = mk(0,  0,  0,  0,  0, 0, 0, 0,  0,  0,   0,   0,  0,  0,    'h0,       0,  0); // post-reset idle
        tbl[2]  = mk(1,  1,  2,  0,  0, 5, 1, 1,  0,  0,   0,   0,  0,  0,    'h20,      1,  0); // FDIV rd=5
        tbl[3]  = mk(1,  5,  6,  0,  0, 10,1, 1,  0,  0,   0,   1,  0,  0,    'h20,      1,  0); // FADD rs1=5 stalls
        tbl[4]  = mk(1,  5,  6,  0,  0, 10,1, 1,  1,  5,   0,   1,  0,  0,    'h0,       0,  0); // wb 5, no bypass
        tbl[5]  = mk(1,  5,  6,  0,  0, 10,1, 1,  0,  0,   0,   0,  0,  0,    'h400,     1,  0); // FADD accepted
        tbl[6]  = mk(0,  0,  0,  0,  0, 0, 0, 0,  1,  10,  0,   0,  0,  0,    'h0,       0,  0); // wb 10
        tbl[7]  = mk(1,  1,  2,  0,  0, 7, 1, 1,  0,  0,   0,   0,  0,  0,    'h80,      1,  0); // load rd=7
        tbl[8]  = mk(1,  1,  2,  0,  0, 7, 1, 1,  0,  0,   0,   0,  1,  0,    'h80,      1,  0); // long rd=7 WAW
        tbl[9]  = mk(1,  1,  2,  0,  0, 7, 1, 0,  0,  0,   0,   0,  1,  0,    'h80,      1,  0); // ADD rd=7 WAW
        tbl[10] = mk(0,  0,  0,  0,  0, 0, 0, 0,  1,  7,   0,   0,  0,  0,    'h0,       0,  0); // wb 7
        tbl[11] = mk(1,  0,  0,  0,  0, 2, 1, 1,  0,  0,   0,   0,  0,  0,    'h4,       1,  0); // long rd=2
        tbl[12] = mk(1,  0,  0,  0,  0, 3, 1, 1,  1,  2,   0,   0,  0,  0,    'h8,       1,  0); // rd=3 + wb 2
        tbl[13] = mk(0,  0,  0,  0,  0, 0, 0, 0,  1,  3,   0,   0,  0,  0,    'h0,       0,  0); // wb 3
        tbl[14] = mk(1,  0,  0,  0,  0, 4, 1, 1,  0,  0,   0,   0,  0,  0,    'h10,      1,  0); // long rd=4
        tbl[15] = mk(1,  1,  2,  4,  0, 11,1, 0,  0,  0,   0,   0,  0,  0,    'h10,      1,  0); // rs3=4 unused
        tbl[16] = mk(1,  1,  2,  4,  1, 11,1, 1,  0,  0,   0,   1,  0,  0,    'h10,      1,  0); // rs3=4 live
        tbl[17] = mk(1,  0,  0,  0,  0, 0, 1, 1,  0,  0,   0,   0,  0,  0,    'h10,      1,  0); // long rd=0
        tbl[18] = mk(0,  0,  0,  0,  0, 0, 0, 0,  1,  4,   0,   0,  0,  0,    'h0,       0,  0); // wb 4
        tbl[19] = mk(0,  0,  0,  0,  0, 0, 0, 0,  1,  6,   0,   0,  0,  0,    'h0,       0,  1); // spurious wb 6
        tbl[20] = mk(0,  0,  0,  0,  0, 0, 0, 0,  1,  0,   0,   0,  0,  0,    'h0,       0,  1); // wb x0, sticky
        tbl[21] = mk(1,  0,  0,  0,  0, 1, 1, 1,  0,  0,   0,   0,  0,  0,    'h2,       1,  1);
        tbl[22] = mk(1,  0,  0,  0,  0, 2, 1, 1,  0,  0,   0,   0,  0,  0,    'h6,       2,  1);
        tbl[23] = mk(1,  0,  0,  0,  0, 3, 1, 1,  0,  0,   0,   0,  0,  0,    'he,       3,  1);
        tbl[24] = mk(1,  0,  0,  0,  0, 4, 1, 1,  1,  1,   1,   0,  0,  0,    'h0,       0,  0); // rst overrides
        tbl[25] = mk(0,  0,  0,  0,  0, 0, 0, 0,  1,  2,   0,   0,  0,  0,    'h0,       0,  1); // stale wb after rst
        tbl[26] = mk(0,  0,  0,  0,  0, 0, 0, 0,  0,  0,   1,   0,  0,  0,    'h0,       0,  0); // reset again

        @(posedge clk);
        #1;
        for (int i = 0; i < 27; i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Fill the tracker with rd=1..8, then exercise the full boundary.
        for (int r = 1; r <= 8; r++) begin
            apply(mk(1, 0, 0, 0, 0, r, 1, 1, 0, 0, 0, 0, 0, 0,
                     (1 << (r + 1)) - 2, r, 0), $sformatf("fill%0d", r));
        end
        apply(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 1, 'h1fe, 8, 0), "full_long9");
        apply(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 'h1fe, 8, 0), "full_short9");
        apply(mk(1, 0, 0, 0, 0, 9, 1, 1, 1, 1, 0, 0, 0, 1, 'h1fc, 7, 0), "full_wb1");
        apply(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 0, 'h3fc, 8, 0), "full_accept9");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h0,   0, 0), "final_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
